register_file_sb: RTL and testbench

Parametrised, scoreboarded register file for the MIPS datapath, the successor to the fixed 16×32 file. It supplies two combinational read ports to the A/B operand registers and one write port from write-back. It also holds a per-register busy (pending-write) bit, which lets the control block reserve a destination at issue and detect read-after-write hazards on operands before writeback completes. All state updates occur on the rising edge of `clk`; the negedge scheme is dropped.

---
 rtl/register_file_sb.sv | 112 +++++++++++
 tb/tb_register_file_sb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb: scoreboarded register file, two combinational read ports, one write port, per-register busy bits.
// Define REGFILE_BYPASS_EN to forward write-back data and busy clearing to the read ports in the same cycle.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_addr,
    output logic              res_ok,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic [ADDR_W:0]   busy_count
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_act;
    logic              res_act;

    function automatic logic is_hardwired(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (ADDR_W+1)'(vec[i]);
        end
        return cnt;
    endfunction

    // A hardwired zero register never stores data and never becomes busy.
    assign wr_act  = wr_en && !is_hardwired(wr_addr);
    assign res_ok  = !busy[res_addr] && !flush;
    assign res_act = res_en && res_ok && !is_hardwired(res_addr);

    // Set is applied after clear so a same-cycle reserve of the written register wins.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_act) busy_nxt[wr_addr] = 1'b0;
            if (res_act) busy_nxt[res_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_act) regs[wr_addr] <= wr_data;
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed while reset is held so reads stay at zero.
    logic fwd;
    assign fwd = wr_act && rst;
`endif

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
        if (fwd && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            rd_busy_a = 1'b0;
        end
`endif
        if (is_hardwired(rd_addr_a)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (fwd && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            rd_busy_b = 1'b0;
        end
`endif
        if (is_hardwired(rd_addr_b)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb (ZERO_REG=1): directed vector table followed by randomized traffic against a reference model.
module tb_register_file_sb;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam bit ZR = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          res_en;
    logic [AW-1:0] res_addr;
    logic          res_ok;
    logic          flush;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          rd_busy_a;
    logic          rd_busy_b;
    logic [AW:0]   busy_count;

    register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_en(res_en), .res_addr(res_addr), .res_ok(res_ok), .flush(flush),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic          rst, wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          res_en;
        logic [AW-1:0] res_addr;
        logic          flush;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] ea, eb;
        logic          eba, ebb, eok;
        logic [AW:0]   ecnt;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] rsa,
                                input logic fl, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                                input logic eba, input logic ebb, input logic eok,
                                input logic [AW:0] ecnt);
        vec_t v;
        v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.res_en = re;
        v.res_addr = rsa; v.flush = fl; v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
        v.eba = eba; v.ebb = ebb; v.eok = eok; v.ecnt = ecnt;
        return v;
    endfunction

    // Reference model state: register contents and pending-write set.
    logic [DW-1:0] m_regs [16];
    logic [15:0]   m_busy;

    function automatic logic hw0(input logic [AW-1:0] a);
        return ZR && (a == 4'd0);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (hw0(a)) return '0;
        if (BYP && rst && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (hw0(a)) return 1'b0;
        if (BYP && rst && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_step();
        logic accept;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            accept = !m_busy[res_addr] && !flush;
            if (flush) m_busy = '0;
            if (wr_en && !hw0(wr_addr)) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (res_en && accept && !hw0(res_addr)) m_busy[res_addr] = 1'b1;
        end
    endtask

    initial begin
        tbl[0]  = mk(0,1,5,32'h1234,1,3,0, 5,3, 0,0,0,0,1,0);
        tbl[1]  = mk(0,1,5,32'hAAAA,1,5,1, 5,5, 0,0,0,0,0,0);
        tbl[2]  = mk(1,1,5,32'hDEADBEEF,0,3,0, 5,0, BYP ? 32'hDEADBEEF : 32'h0,0,0,0,1,0);
        tbl[3]  = mk(1,0,0,0,1,3,0, 5,3, 32'hDEADBEEF,0,0,0,1,0);
        tbl[4]  = mk(1,0,0,0,0,3,0, 3,5, 0,32'hDEADBEEF,1,0,0,1);
        tbl[5]  = mk(1,1,3,32'h12,0,3,0, 3,3, BYP ? 32'h12 : 32'h0, BYP ? 32'h12 : 32'h0, !BYP,!BYP,0,1);
        tbl[6]  = mk(1,0,0,0,0,3,0, 3,3, 32'h12,32'h12,0,0,1,0);
        tbl[7]  = mk(1,1,7,32'h55,1,7,0, 7,7, BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, 0,0,1,0);
        tbl[8]  = mk(1,0,0,0,1,7,0, 7,7, 32'h55,32'h55,1,1,0,1);
        tbl[9]  = mk(1,0,0,0,0,7,0, 7,7, 32'h55,32'h55,1,1,0,1);
        tbl[10] = mk(1,0,0,0,1,1,0, 1,2, 0,0,0,0,1,1);
        tbl[11] = mk(1,0,0,0,1,2,0, 1,2, 0,0,1,0,1,2);
        tbl[12] = mk(1,0,0,0,1,4,0, 2,4, 0,0,1,0,1,3);
        tbl[13] = mk(1,1,1,32'hA5,1,9,1, 1,4, BYP ? 32'hA5 : 32'h0, 0, !BYP,1,0,4);
        tbl[14] = mk(1,0,0,0,0,9,0, 1,9, 32'hA5,0,0,0,1,0);
        tbl[15] = mk(1,1,0,32'hFFFFFFFF,1,0,0, 0,0, 0,0,0,0,1,0);
        tbl[16] = mk(1,0,0,0,0,0,0, 0,7, 0,32'h55,0,0,1,0);
        tbl[17] = mk(1,1,10,32'hCAFE,0,10,0, 10,10, BYP ? 32'hCAFE : 32'h0, BYP ? 32'hCAFE : 32'h0, 0,0,1,0);
        tbl[18] = mk(1,0,0,0,0,10,0, 10,10, 32'hCAFE,32'hCAFE,0,0,1,0);
        tbl[19] = mk(1,0,0,0,1,3,0, 5,3, 32'hDEADBEEF,32'h12,0,0,1,0);
        tbl[20] = mk(0,0,0,0,0,3,0, 5,3, 32'hDEADBEEF,32'h12,0,1,0,1);
        tbl[21] = mk(1,0,0,0,0,3,0, 5,3, 0,0,0,0,1,0);

        rst = 0; wr_en = 1; wr_addr = 4'd2; wr_data = 32'h77; res_en = 1; res_addr = 4'd6;
        flush = 0; rd_addr_a = 4'd2; rd_addr_b = 4'd6;
        @(posedge clk); #1;

        // Directed vectors: inputs applied, outputs sampled at the falling edge, then one rising edge.
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr;
            wr_data = tbl[i].wr_data; res_en = tbl[i].res_en; res_addr = tbl[i].res_addr;
            flush = tbl[i].flush; rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
            @(negedge clk);
            chk($sformatf("v%0d rd_data_a", i), rd_data_a, tbl[i].ea);
            chk($sformatf("v%0d rd_data_b", i), rd_data_b, tbl[i].eb);
            chk($sformatf("v%0d rd_busy_a", i), 32'(rd_busy_a), 32'(tbl[i].eba));
            chk($sformatf("v%0d rd_busy_b", i), 32'(rd_busy_b), 32'(tbl[i].ebb));
            chk($sformatf("v%0d res_ok", i), 32'(res_ok), 32'(tbl[i].eok));
            chk($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(tbl[i].ecnt));
            @(posedge clk); #1;
        end

        // Randomized traffic: one reset cycle to align the model, then random ops.
        rst = 0;
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(31, 0) != 0);
            wr_en     = $urandom_range(1, 0) == 1;
            wr_addr   = 4'($urandom_range(15, 0));
            wr_data   = $urandom;
            res_en    = $urandom_range(1, 0) == 1;
            res_addr  = 4'($urandom_range(15, 0));
            flush     = ($urandom_range(15, 0) == 0);
            rd_addr_a = ($urandom_range(3, 0) == 0) ? wr_addr : 4'($urandom_range(15, 0));
            rd_addr_b = ($urandom_range(3, 0) == 0) ? rd_addr_a : 4'($urandom_range(15, 0));
            @(negedge clk);
            chk("rnd rd_data_a", rd_data_a, exp_data(rd_addr_a));
            chk("rnd rd_data_b", rd_data_b, exp_data(rd_addr_b));
            chk("rnd rd_busy_a", 32'(rd_busy_a), 32'(exp_busy(rd_addr_a)));
            chk("rnd rd_busy_b", 32'(rd_busy_b), 32'(exp_busy(rd_addr_b)));
            chk("rnd res_ok", 32'(res_ok), 32'(!m_busy[res_addr] && !flush));
            chk("rnd busy_count", 32'(busy_count), 32'($countones(m_busy)));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
